// File: rtl/line_cordic_div_if.sv
// Operand/result handshake bundle for the linear-mode CORDIC divider.
interface line_cordic_div_if #(
    parameter int DSIZE = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [DSIZE-1:0] x_in;
    logic signed [DSIZE-1:0] y_in;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [DSIZE:0]   z_out;
    logic                    err;
    logic                    range_err;

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, z_out, err, range_err
    );

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, z_out, err, range_err
    );
endinterface

// File: rtl/line_cordic_div.sv
// Iterative linear-mode CORDIC in vectoring mode: drives y toward zero while
// accumulating 2^(DSIZE-1)>>i into z, so z converges to y/x (1.0 = 2^(DSIZE-1)).
module line_cordic_div #(
    parameter int DSIZE = 16,
    parameter int ITER  = 15
) (
    input logic              clock,
    input logic              rst_n,
    line_cordic_div_if.slave bus
);
    localparam int IW = $clog2(DSIZE) + 1;
    localparam logic [DSIZE:0] DZ0 = {2'b01, {(DSIZE-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic signed [DSIZE+1:0] r_x;
    logic signed [DSIZE+1:0] r_y;
    logic signed [DSIZE:0]   r_z;
    logic [IW-1:0]           r_i;
    logic signed [DSIZE:0]   r_zout;
    logic                    r_err;
    logic                    r_rerr;

    logic                    w_accept;
    logic                    w_out_hs;
    logic                    w_last;
    logic                    w_x_bad;
    logic                    w_range;
    logic signed [DSIZE:0]   w_x_ext;
    logic signed [DSIZE:0]   w_y_ext;
    logic signed [DSIZE:0]   w_absy;
    logic signed [DSIZE+1:0] w_xs;
    logic signed [DSIZE:0]   w_dz;
    logic signed [DSIZE+1:0] w_y_next;
    logic signed [DSIZE:0]   w_z_next;

    assign w_accept = bus.in_valid && (r_state == IDLE);
    assign w_out_hs = bus.out_ready && (r_state == DONE);
    assign w_last   = (r_i == IW'(ITER - 1));

    // Operand qualification: divide error and out-of-range dividend.
    always_comb begin
        w_x_ext = {bus.x_in[DSIZE-1], bus.x_in};
        w_y_ext = {bus.y_in[DSIZE-1], bus.y_in};
        w_absy  = w_y_ext[DSIZE] ? -w_y_ext : w_y_ext;
        w_x_bad = (bus.x_in <= 0);
        w_range = (w_absy >= w_x_ext);
    end

    // One vectoring iteration: step y toward zero, move z by the matching increment.
    always_comb begin
        w_xs = r_x >>> r_i;
        w_dz = DZ0 >> r_i;
        if (r_y >= 0) begin
            w_y_next = r_y - w_xs;
            w_z_next = r_z + w_dz;
        end else begin
            w_y_next = r_y + w_xs;
            w_z_next = r_z - w_dz;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_state_next  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_next = w_x_bad ? DONE : RUN;
            end
            RUN: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_z    <= '0;
            r_i    <= '0;
            r_zout <= '0;
            r_err  <= 1'b0;
            r_rerr <= 1'b0;
        end else if (w_accept) begin
            r_x    <= {{2{bus.x_in[DSIZE-1]}}, bus.x_in};
            r_y    <= {{2{bus.y_in[DSIZE-1]}}, bus.y_in};
            r_z    <= '0;
            r_i    <= '0;
            r_rerr <= w_range;
            if (w_x_bad) begin
                r_err  <= 1'b1;
                r_zout <= '0;
            end
        end else if (r_state == RUN) begin
            r_y <= w_y_next;
            r_z <= w_z_next;
            r_i <= r_i + 1'b1;
            if (w_last) r_zout <= w_z_next;
        end else if (w_out_hs) begin
            r_err  <= 1'b0;
            r_rerr <= 1'b0;
        end
    end

    assign bus.z_out     = r_zout;
    assign bus.err       = r_err;
    assign bus.range_err = r_rerr;
endmodule
